// File: rtl/ft_fifo_ctrl.sv
// FT2232H asynchronous FIFO port sequencer: flag sync, rd_n/wr_n strobe timing, bus arbitration.
// Optional FT_FIFO_CTRL_RR_EN: round-robin read/write grant instead of fixed read priority.
module ft_fifo_ctrl #(
    parameter int RD_PULSE = 2,
    parameter int WR_SETUP = 1,
    parameter int WR_PULSE = 2,
    parameter int RECOVER  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxf_n,
    input  logic       txe_n,
    output logic       rd_n,
    output logic       wr_n,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [2:0] state_dbg
);

    localparam int MAX_AB = (RD_PULSE > WR_SETUP) ? RD_PULSE : WR_SETUP;
    localparam int MAX_CD = (WR_PULSE > RECOVER) ? WR_PULSE : RECOVER;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_STROBE = 3'd1,
        S_WR_SETUP  = 3'd2,
        S_WR_STROBE = 3'd3,
        S_RECOVER   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    rxf_sync_q, rxf_sync_d;
    logic [1:0]    txe_sync_q, txe_sync_d;
    logic          rd_n_q, rd_n_d;
    logic          wr_n_q, wr_n_d;
    logic          data_oe_q, data_oe_d;
    logic [7:0]    data_out_q, data_out_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          tx_ready_q, tx_ready_d;
`ifdef FT_FIFO_CTRL_RR_EN
    logic          ptr_q, ptr_d;   // 0 = RX side preferred, 1 = TX side preferred
`endif

    logic s_rxf_n, s_txe_n;
    logic rd_ok, wr_ok, grant_rd, grant_wr;

    assign s_rxf_n = rxf_sync_q[1];
    assign s_txe_n = txe_sync_q[1];

    // Streams: rx byte transfers on rx_valid & rx_ready; tx byte is latched in the
    // cycle before tx_ready pulses, so the producer may drop tx_valid once it sees tx_ready.
    always_comb begin
        rd_ok    = !s_rxf_n && !rx_valid_q;
        wr_ok    = !s_txe_n && tx_valid;
`ifdef FT_FIFO_CTRL_RR_EN
        grant_rd = rd_ok && (!wr_ok || !ptr_q);
`else
        grant_rd = rd_ok;
`endif
        grant_wr = wr_ok && !grant_rd;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rxf_sync_d = {rxf_sync_q[0], rxf_n};
        txe_sync_d = {txe_sync_q[0], txe_n};
        rd_n_d     = rd_n_q;
        wr_n_d     = wr_n_q;
        data_oe_d  = data_oe_q;
        data_out_d = data_out_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        tx_ready_d = 1'b0;
`ifdef FT_FIFO_CTRL_RR_EN
        ptr_d      = ptr_q;
`endif

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (grant_rd) begin
                    rd_n_d  = 1'b0;
                    cnt_d   = CW'(RD_PULSE - 1);
                    state_d = S_RD_STROBE;
`ifdef FT_FIFO_CTRL_RR_EN
                    ptr_d   = 1'b1;
`endif
                end else if (grant_wr) begin
                    data_out_d = tx_data;
                    data_oe_d  = 1'b1;
                    tx_ready_d = 1'b1;
                    cnt_d      = CW'(WR_SETUP - 1);
                    state_d    = S_WR_SETUP;
`ifdef FT_FIFO_CTRL_RR_EN
                    ptr_d      = 1'b0;
`endif
                end
            end
            S_RD_STROBE: begin
                if (cnt_q == '0) begin
                    rx_data_d  = data_in;
                    rx_valid_d = 1'b1;
                    rd_n_d     = 1'b1;
                    cnt_d      = CW'(RECOVER - 1);
                    state_d    = S_RECOVER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WR_SETUP: begin
                if (cnt_q == '0) begin
                    wr_n_d  = 1'b0;
                    cnt_d   = CW'(WR_PULSE - 1);
                    state_d = S_WR_STROBE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WR_STROBE: begin
                if (cnt_q == '0) begin
                    wr_n_d  = 1'b1;
                    cnt_d   = CW'(RECOVER - 1);
                    state_d = S_RECOVER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RECOVER: begin
                // Bus stays driven through the first recovery cycle for write hold time.
                data_oe_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rxf_sync_q <= 2'b11;
            txe_sync_q <= 2'b11;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            data_oe_q  <= 1'b0;
            data_out_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
`ifdef FT_FIFO_CTRL_RR_EN
            ptr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rxf_sync_q <= rxf_sync_d;
            txe_sync_q <= txe_sync_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            data_oe_q  <= data_oe_d;
            data_out_q <= data_out_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
`ifdef FT_FIFO_CTRL_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign rd_n      = rd_n_q;
    assign wr_n      = wr_n_q;
    assign data_oe   = data_oe_q;
    assign data_out  = data_out_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_ready  = tx_ready_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ft_fifo_ctrl.sv
// Directed bench for ft_fifo_ctrl: read, back-pressure, write, contention, reset mid-write.
// Expected arbitration order follows FT_FIFO_CTRL_RR_EN when it is defined for the build.
module tb_ft_fifo_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       rxf_n, txe_n;
    logic       rd_n, wr_n;
    logic [7:0] data_in, data_out;
    logic       data_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [2:0] state_dbg;

    int n_pass  = 0;
    int n_total = 0;

    ft_fifo_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .rxf_n    (rxf_n),
        .txe_n    (txe_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    // Strobe-order log and bus invariants, sampled on the inactive edge.
    logic [7:0] order_q[$];
    int         inv_viol = 0;
    logic       prev_rd = 1'b1;
    logic       prev_wr = 1'b1;

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (rd_n === 1'b0 && wr_n === 1'b0) inv_viol++;
            if (data_oe === 1'b1 && rd_n === 1'b0) inv_viol++;
            if (prev_rd === 1'b1 && rd_n === 1'b0) order_q.push_back("R");
            if (prev_wr === 1'b1 && wr_n === 1'b0) order_q.push_back("W");
        end
        prev_rd = rd_n;
        prev_wr = wr_n;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic int count_of(input logic [7:0] c);
        int k = 0;
        foreach (order_q[i]) if (order_q[i] == c) k++;
        return k;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        n_total++;
        if ({rd_n, wr_n, data_oe, tx_ready, rx_valid} !== 5'b11000)
            $display("FAIL reset_ctrl: got %b want 11000", {rd_n, wr_n, data_oe, tx_ready, rx_valid});
        else n_pass++;
        n_total++;
        if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h want 00", data_out);
        else n_pass++;
        n_total++;
        if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data);
        else n_pass++;
        n_total++;
        if (state_dbg !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_dbg);
        else n_pass++;
        reset = 1'b0;
        tick(2);
        n_total++;
        if ({rd_n, wr_n, data_oe} !== 3'b110)
            $display("FAIL reset_quiet: got %b want 110", {rd_n, wr_n, data_oe});
        else n_pass++;
    endtask

    task automatic test_read;
        logic [9:0] rd_hist = '0;
        logic [9:0] vld_hist = '0;
        logic [7:0] got = '0;
        data_in  = 8'hA5;
        rx_ready = 1'b1;
        rxf_n    = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            rd_hist  = {rd_hist[8:0], rd_n};
            vld_hist = {vld_hist[8:0], rx_valid};
            if (i == 5) got = rx_data;
            if (i == 4) rxf_n = 1'b1;
        end
        n_total++;
        if (rd_hist !== 10'b1100111111) $display("FAIL read_rd_n: got %b want 1100111111", rd_hist);
        else n_pass++;
        n_total++;
        if (vld_hist !== 10'b0000100000) $display("FAIL read_rx_valid: got %b want 0000100000", vld_hist);
        else n_pass++;
        n_total++;
        if (got !== 8'hA5) $display("FAIL read_rx_data: got %h want a5", got);
        else n_pass++;
        tick(4);
    endtask

    task automatic test_back_pressure;
        int r0;
        r0 = count_of("R");
        rx_ready = 1'b0;
        data_in  = 8'h11;
        rxf_n    = 1'b0;
        tick(20);
        n_total++;
        if (count_of("R") - r0 !== 1) $display("FAIL bp_one_read: got %0d want 1", count_of("R") - r0);
        else n_pass++;
        n_total++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11)
            $display("FAIL bp_held: got valid=%b data=%h want valid=1 data=11", rx_valid, rx_data);
        else n_pass++;
        data_in  = 8'h22;
        rx_ready = 1'b1;
        tick(4);
        n_total++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h22)
            $display("FAIL bp_second: got valid=%b data=%h want valid=1 data=22", rx_valid, rx_data);
        else n_pass++;
        rxf_n = 1'b1;
        tick(8);
        n_total++;
        if (count_of("R") - r0 !== 2) $display("FAIL bp_two_reads: got %0d want 2", count_of("R") - r0);
        else n_pass++;
        n_total++;
        if (rx_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", rx_valid);
        else n_pass++;
    endtask

    task automatic test_write;
        logic [8:0] wr_hist = '0;
        logic [8:0] oe_hist = '0;
        logic [8:0] rdy_hist = '0;
        logic [7:0] got = '0;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        txe_n    = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            wr_hist  = {wr_hist[7:0], wr_n};
            oe_hist  = {oe_hist[7:0], data_oe};
            rdy_hist = {rdy_hist[7:0], tx_ready};
            if (tx_ready === 1'b1) begin
                tx_valid = 1'b0;
                tx_data  = 8'hFF;
            end
            if (i == 5) begin
                got   = data_out;
                txe_n = 1'b1;
            end
        end
        n_total++;
        if (rdy_hist !== 9'b001000000) $display("FAIL write_tx_ready: got %b want 001000000", rdy_hist);
        else n_pass++;
        n_total++;
        if (oe_hist !== 9'b001111000) $display("FAIL write_oe: got %b want 001111000", oe_hist);
        else n_pass++;
        n_total++;
        if (wr_hist !== 9'b111001111) $display("FAIL write_wr_n: got %b want 111001111", wr_hist);
        else n_pass++;
        n_total++;
        if (got !== 8'h3C) $display("FAIL write_data_out: got %h want 3c", got);
        else n_pass++;
        tick(4);
    endtask

    task automatic test_contention;
        logic [31:0] got = '0;
        int          w_in_window;
        bit          seen_w = 0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        order_q.delete();
        data_in  = 8'h5A;
        tx_data  = 8'h77;
        rx_ready = 1'b1;
        tx_valid = 1'b1;
        rxf_n    = 1'b0;
        txe_n    = 1'b0;
        tick(32);
        for (int i = 0; i < 4; i++)
            got = {got[23:0], (i < order_q.size()) ? order_q[i] : 8'h2D};
`ifdef FT_FIFO_CTRL_RR_EN
        n_total++;
        if (got !== "RWRW") $display("FAIL contention_rr: got %s want RWRW", got);
        else n_pass++;
        rxf_n    = 1'b1;
        txe_n    = 1'b1;
        tx_valid = 1'b0;
`else
        w_in_window = count_of("W");
        n_total++;
        if (got[31:8] !== "RRR" || w_in_window !== 0)
            $display("FAIL contention_fixed: got %s writes=%0d want RRR writes=0", got, w_in_window);
        else n_pass++;
        rxf_n = 1'b1;
        for (int i = 0; i < 30 && !seen_w; i++) begin
            tick(1);
            if (count_of("W") > 0) seen_w = 1;
        end
        n_total++;
        if (!seen_w) $display("FAIL contention_write_after_rx: got no write want write");
        else n_pass++;
        txe_n    = 1'b1;
        tx_valid = 1'b0;
`endif
        tick(16);
    endtask

    task automatic test_reset_mid_write;
        bit seen = 0;
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        txe_n    = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick(1);
            if (tx_ready === 1'b1) tx_valid = 1'b0;
            if (wr_n === 1'b0) seen = 1;
        end
        n_total++;
        if (!seen) $display("FAIL rmw_strobe_timeout: got no wr_n low want wr_n low");
        else n_pass++;
        reset = 1'b1;
        tick(1);
        n_total++;
        if ({wr_n, rd_n, data_oe, tx_ready} !== 4'b1100)
            $display("FAIL rmw_abort_ctrl: got %b want 1100", {wr_n, rd_n, data_oe, tx_ready});
        else n_pass++;
        n_total++;
        if (state_dbg !== 3'd0) $display("FAIL rmw_abort_state: got %0d want 0", state_dbg);
        else n_pass++;
        n_total++;
        if (data_out !== 8'h00) $display("FAIL rmw_abort_data: got %h want 00", data_out);
        else n_pass++;
        reset    = 1'b0;
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (tx_ready === 1'b1) tx_valid = 1'b0;
            if (wr_n === 1'b0) seen = 1;
        end
        n_total++;
        if (!seen) $display("FAIL rmw_fresh_timeout: got no wr_n low want wr_n low");
        else n_pass++;
        n_total++;
        if (data_out !== 8'h96 || data_oe !== 1'b1)
            $display("FAIL rmw_fresh_bus: got data=%h oe=%b want data=96 oe=1", data_out, data_oe);
        else n_pass++;
        txe_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick(1);
            if (wr_n === 1'b1) seen = 1;
        end
        n_total++;
        if (!seen || data_oe !== 1'b1)
            $display("FAIL rmw_fresh_hold: got rise=%0d oe=%b want rise=1 oe=1", seen, data_oe);
        else n_pass++;
        tick(1);
        n_total++;
        if (data_oe !== 1'b0) $display("FAIL rmw_fresh_oe_drop: got %b want 0", data_oe);
        else n_pass++;
        tick(6);
    endtask

    task automatic test_invariants;
        n_total++;
        if (inv_viol !== 0) $display("FAIL invariants: got %0d violations want 0", inv_viol);
        else n_pass++;
    endtask

    initial begin
        reset    = 1'b1;
        rxf_n    = 1'b1;
        txe_n    = 1'b1;
        data_in  = 8'h00;
        rx_ready = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        test_reset();
        test_read();
        test_back_pressure();
        test_write();
        test_contention();
        test_reset_mid_write();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
